// File: rtl/hilo_ctrl.sv
// EX-stage requester for the multiply/divide unit: launches MULT/DIV on MultDiv,
// stalls EX until the result returns, and owns the architectural HI/LO registers.
module hilo_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        stall_all,
    input  logic        flush,
    output logic        md_start,
    output logic [5:0]  md_funct,
    output logic [31:0] md_op1,
    output logic [31:0] md_op2,
    input  logic        md_done,
    input  logic [63:0] md_result,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        md_timeout
);

    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic              md_start_q, md_start_d;
    logic [5:0]        md_funct_q, md_funct_d;
    logic [31:0]       md_op1_q, md_op1_d, md_op2_q, md_op2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              md_timeout_q, md_timeout_d;

    logic is_md, div_by_zero, issue, hilo_wr, mthi_wr, mtlo_wr, timeout_hit;

    // 0x18..0x1B share the upper four bits; bit 1 selects the divides.
    assign is_md       = (funct[5:2] == 4'b0110);
    assign div_by_zero = funct[1] && (operand_2 == 32'd0);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_BUSY;
            S_BUSY: begin
                if (flush)                 state_d = S_IDLE;
                else if (md_done)          state_d = stall_all ? S_HOLD : S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_IDLE;
            end
            S_HOLD: if (!stall_all || flush) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        stall_req   = 1'b0;
        hilo_wr     = 1'b0;
        mthi_wr     = 1'b0;
        mtlo_wr     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue     = ex_valid && !flush && is_md && !div_by_zero;
                stall_req = issue;
                mthi_wr   = ex_valid && !flush && !stall_all && (funct == F_MTHI);
                mtlo_wr   = ex_valid && !flush && !stall_all && (funct == F_MTLO);
            end
            S_BUSY: begin
                stall_req   = !md_done && !flush;
                hilo_wr     = md_done && !flush;
                timeout_hit = !md_done && !flush && (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        md_start_d   = issue;
        md_funct_d   = issue ? funct     : md_funct_q;
        md_op1_d     = issue ? operand_1 : md_op1_q;
        md_op2_d     = issue ? operand_2 : md_op2_q;
        cnt_d        = cnt_q;
        if (issue)                  cnt_d = '0;
        else if (state_q == S_BUSY) cnt_d = cnt_q + CNT_W'(1);
        hi_d         = hi_q;
        lo_d         = lo_q;
        if (hilo_wr) begin
            hi_d = md_result[63:32];
            lo_d = md_result[31:0];
        end
        if (mthi_wr) hi_d = operand_1;
        if (mtlo_wr) lo_d = operand_1;
        md_timeout_d = md_timeout_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q         <= '0;
            lo_q         <= '0;
            md_start_q   <= 1'b0;
            md_funct_q   <= '0;
            md_op1_q     <= '0;
            md_op2_q     <= '0;
            cnt_q        <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            md_start_q   <= md_start_d;
            md_funct_q   <= md_funct_d;
            md_op1_q     <= md_op1_d;
            md_op2_q     <= md_op2_d;
            cnt_q        <= cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign md_start   = md_start_q;
    assign md_funct   = md_funct_q;
    assign md_op1     = md_op1_q;
    assign md_op2     = md_op2_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
    assign md_timeout = md_timeout_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: issue/stall timing, HI/LO writes, flush, HOLD and watchdog.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2;
    logic        stall_all, flush;
    logic        md_start;
    logic [5:0]  md_funct;
    logic [31:0] md_op1, md_op2;
    logic        md_done;
    logic [63:0] md_result;
    logic        stall_req;
    logic [31:0] hi_out, lo_out;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int double_start = 0;
    logic prev_start = 1'b0;
    int n;

    hilo_ctrl dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .stall_all(stall_all),
        .flush(flush), .md_start(md_start), .md_funct(md_funct),
        .md_op1(md_op1), .md_op2(md_op2), .md_done(md_done),
        .md_result(md_result), .stall_req(stall_req), .hi_out(hi_out),
        .lo_out(lo_out), .md_timeout(md_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (md_start) start_cnt++;
        if (md_start && prev_start) double_start++;
        prev_start = md_start;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b0; funct = 6'h0; operand_1 = '0; operand_2 = '0;
        stall_all = 1'b0; flush = 1'b0; md_done = 1'b0; md_result = '0;
        tick(); tick();
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_start", md_start, 0);
        check("rst_timeout", md_timeout, 0);
        check("rst_funct", md_funct, 0);
        check("rst_op1", md_op1, 0);
        check("rst_stall", stall_req, 0);
        rst = 1'b1;
        tick();

        // DIVU by zero: ignored entirely
        ex_valid = 1'b1; funct = 6'h1B; operand_1 = 32'd7; operand_2 = 32'd0;
        #1 check("div0_stall", stall_req, 0);
        tick();
        check("div0_start", md_start, 0);
        check("div0_hi", hi_out, 0);
        check("div0_lo", lo_out, 0);
        check("div0_nostart", start_cnt, 0);

        // MULT, done in the 4th BUSY cycle
        funct = 6'h18; operand_1 = 32'hFFFF_FFFE; operand_2 = 32'd3;
        #1 check("mult_issue_stall", stall_req, 1);
        tick();
        check("mult_b1_start", md_start, 1);
        check("mult_b1_stall", stall_req, 1);
        check("mult_funct", md_funct, 6'h18);
        check("mult_op1", md_op1, 32'hFFFF_FFFE);
        check("mult_op2", md_op2, 32'd3);
        tick();
        check("mult_b2_start", md_start, 0);
        check("mult_b2_stall", stall_req, 1);
        tick();
        check("mult_b3_stall", stall_req, 1);
        tick();
        md_done = 1'b1; md_result = 64'hFFFF_FFFF_FFFF_FFFA;
        #1 check("mult_done_stall", stall_req, 0);
        tick();
        md_done = 1'b0; ex_valid = 1'b0;
        check("mult_hi", hi_out, 32'hFFFF_FFFF);
        check("mult_lo", lo_out, 32'hFFFF_FFFA);
        check("mult_one_start", start_cnt, 1);

        // MTHI / MTLO
        ex_valid = 1'b1; funct = 6'h11; operand_1 = 32'h1234_5678;
        tick();
        check("mthi_hi", hi_out, 32'h1234_5678);
        funct = 6'h13; operand_1 = 32'h9ABC_DEF0;
        tick();
        check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
        check("mtlo_hi", hi_out, 32'h1234_5678);
        funct = 6'h11; operand_1 = 32'hDEAD_BEEF; stall_all = 1'b1;
        tick();
        check("mthi_stalled", hi_out, 32'h1234_5678);
        stall_all = 1'b0; ex_valid = 1'b0;

        // DIV flushed in the 2nd BUSY cycle; late md_done ignored
        ex_valid = 1'b1; funct = 6'h1A; operand_1 = 32'd100; operand_2 = 32'd7;
        #1 check("div_issue_stall", stall_req, 1);
        tick();
        check("div_b1_start", md_start, 1);
        tick();
        flush = 1'b1;
        #1 check("div_flush_stall", stall_req, 0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        md_done = 1'b1; md_result = 64'hAAAA_AAAA_5555_5555;
        #1 check("div_late_stall", stall_req, 0);
        tick();
        md_done = 1'b0;
        check("div_hi", hi_out, 32'h1234_5678);
        check("div_lo", lo_out, 32'h9ABC_DEF0);
        check("div_starts", start_cnt, 2);

        // MULTU done under stall_all, then HOLD for 3 cycles
        ex_valid = 1'b1; funct = 6'h19; operand_1 = 32'd16; operand_2 = 32'd32;
        #1 check("multu_issue_stall", stall_req, 1);
        tick();
        check("multu_b1_start", md_start, 1);
        tick();
        md_done = 1'b1; md_result = 64'h1111_1111_2222_2222; stall_all = 1'b1;
        #1 check("multu_done_stall", stall_req, 0);
        tick();
        md_done = 1'b0;
        check("hold1_stall", stall_req, 0);
        check("multu_hi", hi_out, 32'h1111_1111);
        check("multu_lo", lo_out, 32'h2222_2222);
        tick();
        md_done = 1'b1; md_result = 64'h0BAD_0BAD_0BAD_0BAD;
        #1 check("hold2_stall", stall_req, 0);
        tick();
        md_done = 1'b0;
        check("hold3_stall", stall_req, 0);
        check("hold_hi", hi_out, 32'h1111_1111);
        check("hold_lo", lo_out, 32'h2222_2222);
        tick();
        stall_all = 1'b0; ex_valid = 1'b0;
        tick();
        check("multu_starts", start_cnt, 3);
        ex_valid = 1'b1; funct = 6'h11; operand_1 = 32'hCAFE_F00D;
        tick();
        ex_valid = 1'b0;
        check("post_hold_mthi", hi_out, 32'hCAFE_F00D);

        // Watchdog: md_done never arrives
        ex_valid = 1'b1; funct = 6'h18; operand_1 = 32'd1; operand_2 = 32'd1;
        #1 check("wd_issue_stall", stall_req, 1);
        tick();
        ex_valid = 1'b0;
        check("wd_b1_start", md_start, 1);
        n = 0;
        while (stall_req && n < 200) begin
            n++;
            tick();
        end
        check("wd_busy_cycles", n, 64);
        check("wd_timeout", md_timeout, 1);
        check("wd_hi", hi_out, 32'hCAFE_F00D);
        check("wd_lo", lo_out, 32'h2222_2222);
        check("wd_starts", start_cnt, 4);
        rst = 1'b0;
        tick();
        check("wd_rst_timeout", md_timeout, 0);
        check("wd_rst_hi", hi_out, 0);

        // Reset mid-BUSY, then a stray md_done in IDLE
        rst = 1'b1;
        ex_valid = 1'b1; funct = 6'h18; operand_1 = 32'd5; operand_2 = 32'd5;
        tick();
        ex_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; md_done = 1'b1; md_result = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 check("rstbusy_stall", stall_req, 0);
        tick();
        md_done = 1'b0;
        check("rstbusy_hi", hi_out, 0);
        check("rstbusy_lo", lo_out, 0);
        check("rstbusy_funct", md_funct, 0);
        check("no_double_start", double_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- EX-stage requester for the multiply/divide unit.
- Decodes SPECIAL funct codes, launches MULT/MULTU/DIV/DIVU on the MultDiv unit, and stalls the pipeline until `md_done`.
- Writes the 64-bit result into the architectural HI/LO registers; services MTHI/MTLO/MFHI/MFLO.
- Sits between ID/EX pipeline register and MultDiv; owns HI/LO.

Parameters:
- TIMEOUT_CYCLES, 64, max BUSY cycles before abort (watchdog)
- CNT_W, 7, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- ex_valid  input  1  EX holds a valid SPECIAL-opcode instruction
- funct  input  6  instruction funct field
- operand_1  input  32  rs value
- operand_2  input  32  rt value
- stall_all  input  1  global pipeline stall from other stages
- flush  input  1  EX instruction killed (exception/branch)
- md_start  output  1  one-cycle launch pulse to MultDiv
- md_funct  output  6  latched funct to MultDiv
- md_op1  output  32  latched operand_1
- md_op2  output  32  latched operand_2
- md_done  input  1  MultDiv result valid, one cycle
- md_result  input  64  {hi,lo} from MultDiv
- stall_req  output  1  hold pipeline, combinational
- hi_out  output  32  HI register
- lo_out  output  32  LO register
- md_timeout  output  1  sticky watchdog error flag

Behaviour:
- Funct codes: MFHI=0x10, MTHI=0x11, MFLO=0x12, MTLO=0x13, MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B. All others ignored.
- Reset (rst==0 at edge):
  - state=IDLE; HI=LO=0; md_start=0; md_funct/op1/op2=0; counter=0; md_timeout=0.
  - Reset mid-BUSY drops the operation; a later `md_done` in IDLE is ignored.
- States: IDLE, BUSY, HOLD.
- IDLE, issue condition: `ex_valid && !flush && funct in {0x18..0x1B}`.
  - Divide by zero (DIV/DIVU with operand_2==0): no issue, HI/LO unchanged, stall_req=0, stay IDLE.
  - Otherwise: stall_req=1 this cycle. At the edge, latch funct/operands, md_start=1 for exactly the next cycle, counter=0, go BUSY.
  - The issue happens even when stall_all=1.
- IDLE, move-to writes: `ex_valid && !flush && !stall_all` with MTHI writes HI=operand_1 at the edge; MTLO writes LO=operand_1.
- MFHI/MFLO: hi_out/lo_out are plain register outputs; no bypass needed, because stall covers the in-flight case.
- BUSY:
  - stall_req=1 while md_done=0; counter increments each cycle.
  - On md_done: stall_req=0 that cycle; HI=md_result[63:32] and LO=md_result[31:0] at the edge.
  - After md_done, next state is HOLD if stall_all=1, else IDLE. HOLD prevents re-issue of the same instruction still sitting in EX.
  - On flush (no md_done the same cycle): go IDLE, no HI/LO write, stall_req=0.
  - flush and md_done in the same cycle: the write is suppressed.
  - Watchdog: when counter reaches TIMEOUT_CYCLES-1 without md_done, go IDLE, set md_timeout=1 (sticky until reset), no write.
- HOLD:
  - stall_req=0; no issue, no move-to writes.
  - Exit to IDLE on the first cycle with stall_all=0 or flush=1.
- md_start is only ever high on the first BUSY cycle, never two consecutive cycles.
- md_funct/op1/op2 stay stable from issue until leaving BUSY.
- Widths: md_result is split exactly; no sign manipulation here, because signedness is MultDiv's job.

Test Plan:
- Reset then MULT: ex_valid=1, funct=0x18, op1=0xFFFFFFFE, op2=3, md_done 4 cycles after md_start with md_result=0xFFFFFFFF_FFFFFFFA.
  - Required: stall_req high in the issue cycle and 3 BUSY cycles, low in the done cycle.
  - Required: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA next cycle; md_start pulsed once.
- DIVU with op2=0, op1=7: no md_start, stall_req=0, HI/LO unchanged (0/0 after reset).
- MTHI 0x12345678, then MTLO 0x9ABCDEF0, each with stall_all=0: hi_out=0x12345678, lo_out=0x9ABCDEF0. Repeat the MTHI with stall_all=1: HI unchanged.
- DIV issued, flush asserted on the 2nd BUSY cycle, md_done with 0xAAAA_AAAA_5555_5555 one cycle later: state IDLE, HI/LO unchanged, stall_req=0.
- MULTU done while stall_all=1 for 3 more cycles with ex_valid/funct held: HI/LO written once, exactly one md_start total, stall_req=0 throughout HOLD, IDLE after stall_all drops.
- MULT issued, md_done never asserted, TIMEOUT_CYCLES=64: stall_req high 64 cycles, then md_timeout=1, state IDLE, HI/LO unchanged. Reset clears md_timeout.
